// File: rtl/oloca_pkg.sv
// Shared OLOCA definitions: accumulator FSM states and the OLOCA approximate add.
// oloca_add works on words up to OLOCA_MAX_W bits; callers zero-extend their operands.
package oloca_pkg;

    localparam int OLOCA_MAX_W = 64;

    typedef logic [OLOCA_MAX_W-1:0] oloca_word_t;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } oloca_state_t;

    // Returns {carry_out, sum}. The low imprecise_part-2 bits are forced to one.
    // The next two bits are the OR of the operand bits.
    // The upper field is an exact add whose carry-in is the OR of bit imprecise_part-1.
    function automatic logic [OLOCA_MAX_W:0] oloca_add(
        input oloca_word_t a,
        input oloca_word_t b,
        input int          acc_width,
        input int          imprecise_part
    );
        logic [OLOCA_MAX_W:0] acc_mask;
        logic [OLOCA_MAX_W:0] aw;
        logic [OLOCA_MAX_W:0] bw;
        logic [OLOCA_MAX_W:0] ab;
        logic [OLOCA_MAX_W:0] mask_low;
        logic [OLOCA_MAX_W:0] mask_mid;
        logic [OLOCA_MAX_W:0] cin;
        logic [OLOCA_MAX_W:0] upper;
        logic [OLOCA_MAX_W:0] full;
        logic [OLOCA_MAX_W:0] above;
        acc_mask = (65'd1 << acc_width) - 65'd1;
        aw       = {1'b0, a} & acc_mask;
        bw       = {1'b0, b} & acc_mask;
        ab       = aw | bw;
        mask_low = (65'd1 << (imprecise_part - 2)) - 65'd1;
        mask_mid = ((65'd1 << imprecise_part) - 65'd1) & ~mask_low;
        cin      = (ab >> (imprecise_part - 1)) & 65'd1;
        upper    = (aw >> imprecise_part) + (bw >> imprecise_part) + cin;
        full     = (upper << imprecise_part) | (ab & mask_mid) | mask_low;
        above    = full >> acc_width;
        return {above[0], full[OLOCA_MAX_W-1:0] & acc_mask[OLOCA_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/oloca_acc_core.sv
// Combinational OLOCA add of accumulator and operand, plus optional saturation.
// Macro OLOCA_ACC_SATURATE_EN: force the sum to all ones on a carry-out.
module oloca_acc_core
    import oloca_pkg::*;
#(
    parameter int ACC_WIDTH      = 32,
    parameter int IMPRECISE_PART = 8
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [ACC_WIDTH-1:0] operand,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry
);

    oloca_word_t          acc_ext;
    oloca_word_t          operand_ext;
    logic [OLOCA_MAX_W:0] add_result;
    logic                 unused_high;

    always_comb begin
        acc_ext                       = '0;
        operand_ext                   = '0;
        acc_ext[ACC_WIDTH-1:0]        = acc;
        operand_ext[ACC_WIDTH-1:0]    = operand;
        add_result = oloca_add(acc_ext, operand_ext, ACC_WIDTH, IMPRECISE_PART);
        carry      = add_result[OLOCA_MAX_W];
`ifdef OLOCA_ACC_SATURATE_EN
        // An all-ones accumulator always carries out again, so saturation is self-sustaining.
        sum = carry ? '1 : add_result[ACC_WIDTH-1:0];
`else
        sum = add_result[ACC_WIDTH-1:0];
`endif
    end

    assign unused_high = ^add_result[OLOCA_MAX_W-1:ACC_WIDTH];

endmodule

// File: rtl/oloca_accumulator.sv
// Streaming OLOCA packet accumulator: one beat per cycle in, one sum per packet out.
// Build option OLOCA_ACC_SATURATE_EN selects saturation instead of wrap-around.
module oloca_accumulator
    import oloca_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int IMPRECISE_PART = 8,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_ovf
);

    oloca_state_t           state_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   ovf_reg;
    logic                   first_reg;

    logic [ACC_WIDTH-1:0]   operand;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   carry;

    always_comb begin
        operand                  = '0;
        operand[DATA_WIDTH-1:0]  = in_data;
    end

    oloca_acc_core #(
        .ACC_WIDTH      (ACC_WIDTH),
        .IMPRECISE_PART (IMPRECISE_PART)
    ) u_core (
        .acc     (acc_reg),
        .operand (operand),
        .sum     (acc_next),
        .carry   (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            first_reg <= 1'b1;
        end else begin
            case (state_reg)
                ACC: begin
                    if (in_valid) begin
                        if (first_reg) begin
                            // First beat loads exactly: nothing to approximate against.
                            acc_reg   <= operand;
                            count_reg <= COUNT_WIDTH'(1);
                            ovf_reg   <= 1'b0;
                            first_reg <= 1'b0;
                        end else begin
                            acc_reg   <= acc_next;
                            count_reg <= count_reg + COUNT_WIDTH'(1);
                            ovf_reg   <= ovf_reg | carry;
                        end
                        if (in_last) begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= ACC;
                        first_reg <= 1'b1;
                    end
                end
                default: state_reg <= ACC;
            endcase
        end
    end

    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);
    assign out_sum   = acc_reg;
    assign out_count = count_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_oloca_accumulator.sv
// Self-checking bench: two accumulator builds (32-bit/8-bit count and 16-bit/2-bit count)
// share one stimulus stream and are compared against an arithmetic packet model.
module tb_oloca_accumulator;

    localparam int DW = 16;
    localparam int I  = 8;
    localparam int AW_A = 32;
    localparam int CW_A = 8;
    localparam int AW_B = 16;
    localparam int CW_B = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic            out_ready;

    logic            in_ready_a, out_valid_a, out_ovf_a;
    logic [AW_A-1:0] out_sum_a;
    logic [CW_A-1:0] out_count_a;
    logic            in_ready_b, out_valid_b, out_ovf_b;
    logic [AW_B-1:0] out_sum_b;
    logic [CW_B-1:0] out_count_b;

    int checks   = 0;
    int failures = 0;
    int pkt_num  = 0;
    logic [DW-1:0] pkt[$];

    always #5 clk = ~clk;

    oloca_accumulator #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW_A), .IMPRECISE_PART(I), .COUNT_WIDTH(CW_A)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
        .out_ovf(out_ovf_a)
    );

    oloca_accumulator #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW_B), .IMPRECISE_PART(I), .COUNT_WIDTH(CW_B)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
        .out_ovf(out_ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference OLOCA add from the arithmetic rule on w-bit words.
    function automatic longint unsigned model_add(input longint unsigned a, input longint unsigned b,
                                                  input int w, output bit c);
        longint unsigned ab, hi, mid, low;
        ab  = a | b;
        low = (64'd1 << (I - 2)) - 1;
        mid = ((ab >> (I - 2)) & 64'd3) << (I - 2);
        hi  = (a >> I) + (b >> I) + ((ab >> (I - 1)) & 64'd1);
        c   = ((hi >> (w - I)) & 64'd1) != 0;
        hi  = hi & ((64'd1 << (w - I)) - 1);
        return (hi << I) | mid | low;
    endfunction

    task automatic model_pkt(input int w, input int cw, output longint unsigned sum,
                             output longint unsigned count, output bit ovf);
        bit c;
        sum = pkt[0];
        ovf = 1'b0;
        for (int k = 1; k < pkt.size(); k++) begin
            sum = model_add(sum, pkt[k], w, c);
            ovf = ovf | c;
`ifdef OLOCA_ACC_SATURATE_EN
            if (ovf) sum = (64'd1 << w) - 1;
`endif
        end
        count = pkt.size() % (1 << cw);
    endtask

    task automatic drive_beats(input bit gaps);
        for (int k = 0; k < pkt.size(); k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = pkt[k];
            in_last  = (k == pkt.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends pkt, checks the result on both builds, stalls `hold` cycles, then hands it off.
    task automatic run_pkt(input int hold, input bit gaps);
        longint unsigned sa, ca, sb, cb;
        bit oa, ob;
        model_pkt(AW_A, CW_A, sa, ca, oa);
        model_pkt(AW_B, CW_B, sb, cb, ob);
        out_ready = 1'b0;
        drive_beats(gaps);
        pkt_num++;
        $display("pkt %0d beats=%0d hold=%0d sum32=0x%0h sum16=0x%0h ovf16=%0d",
                 pkt_num, pkt.size(), hold, sa, sb, ob);
        chk("out_valid_a", 64'(out_valid_a), 64'd1);
        chk("out_sum_a", 64'(out_sum_a), sa);
        chk("out_count_a", 64'(out_count_a), ca);
        chk("out_ovf_a", 64'(out_ovf_a), 64'(oa));
        chk("out_valid_b", 64'(out_valid_b), 64'd1);
        chk("out_sum_b", 64'(out_sum_b), sb);
        chk("out_count_b", 64'(out_count_b), cb);
        chk("out_ovf_b", 64'(out_ovf_b), 64'(ob));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_in_ready", 64'(in_ready_a), 64'd0);
            chk("hold_valid", 64'(out_valid_a), 64'd1);
            chk("hold_sum_a", 64'(out_sum_a), sa);
            chk("hold_count_a", 64'(out_count_a), ca);
            chk("hold_sum_b", 64'(out_sum_b), sb);
            chk("hold_ovf_b", 64'(out_ovf_b), 64'(ob));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", 64'(out_valid_a), 64'd0);
        chk("post_in_ready", 64'(in_ready_a), 64'd1);
        chk("post_in_ready_b", 64'(in_ready_b), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_sum", 64'(out_sum_a), 64'd0);
        chk("rst_out_count", 64'(out_count_a), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf_a), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-packet discards the partial sum immediately.
        pkt = '{16'h1234, 16'h0077};
        in_valid = 1'b1; in_data = pkt[0]; in_last = 1'b0;
        @(posedge clk); #1;
        in_data = pkt[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_out_sum", 64'(out_sum_a), 64'd0);
        chk("midrst_out_count", 64'(out_count_a), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_a), 64'd1);
        chk("midrst_out_valid", 64'(out_valid_b), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        pkt = '{16'h0005};                    run_pkt(0, 1'b0);
        pkt = '{16'h0010, 16'h0001};          run_pkt(1, 1'b0);
        pkt = '{16'h00C0, 16'h0080};          run_pkt(5, 1'b0);
        pkt = '{16'hABCD};                    run_pkt(0, 1'b0);
        pkt = '{16'hFF00, 16'h0100};          run_pkt(0, 1'b0);
        pkt = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; run_pkt(2, 1'b0);

        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 9);
            pkt.delete();
            for (int k = 0; k < len; k++) begin
                pkt.push_back(DW'($urandom));
            end
            run_pkt($urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oloca_accumulator.md
# oloca_accumulator

Streaming accumulator that consumes operand packets and reduces each packet into one sum using the OLOCA approximate-addition rule. It sits downstream of the PE product outputs in the APTPU datapath, accepts operands over a valid/ready input port, and presents one sum per packet over a valid/ready output port. All arithmetic happens in a single registered stage.

## Interface
- DATA_WIDTH, 16, operand width; must satisfy IMPRECISE_PART < DATA_WIDTH <= ACC_WIDTH.
- ACC_WIDTH, 32, accumulator and sum width.
- IMPRECISE_PART, 8, number of approximate low bits; must be >= 2.
- COUNT_WIDTH, 8, width of the per-packet beat counter.
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  accumulator can take a beat.
- in_data  input  DATA_WIDTH  unsigned operand, zero-extended to ACC_WIDTH.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  1  packet result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_WIDTH  accumulated packet sum.
- out_count  output  COUNT_WIDTH  beats in the packet, modulo 2^COUNT_WIDTH.
- out_ovf  output  1  sticky flag: a carry left bit ACC_WIDTH-1 during the packet.

## Operation
- Let I = IMPRECISE_PART. oloca(a,b) is defined as follows:
  - bits [I-3:0] = all ones (none when I = 2);
  - bit I-2 = a|b;
  - bit I-1 = a|b;
  - bits [ACC_WIDTH-1:I] = exact ripple sum with carry-in = a[I-1]|b[I-1];
  - the carry-out is the overflow event.
- FSM has two states:
  - ACC: in_ready = 1.
  - HOLD: in_ready = 0; out_valid = 1.
- Accepted beat = in_valid & in_ready.
- On the first beat of a packet, acc loads zero-extended in_data exactly; no approximation, no overflow. count = 1, ovf = 0.
- On each later beat: acc = oloca(acc, in_data); count = count+1 (wraps); ovf |= carry-out.
- If the accepted beat has in_last = 1, the FSM moves to HOLD with the updated acc, count and ovf.
- A single-beat packet yields out_sum = in_data and out_count = 1.
- HOLD persists while out_ready = 0; out_sum, out_count and out_ovf stay stable.
- When out_valid & out_ready, the FSM returns to ACC and the next beat is treated as a first beat.
- Overflow wraps: acc keeps the low ACC_WIDTH bits (see Configuration for saturation).
- in_data is ignored whenever in_valid = 0 or the FSM is in HOLD.

## Timing
- Reset values: state ACC, in_ready = 1, out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0, first-beat flag set.
- Throughput is one beat per cycle in ACC.
- out_valid rises the cycle after the last beat is accepted.
- in_ready is registered-state-derived only; there is no combinational path from out_ready.
- Minimum packet spacing is 1 idle cycle in HOLD when out_ready is held high; the next first beat is accepted the cycle after the handshake.
- rst asserted mid-packet or in HOLD discards all partial state immediately and returns every output to its reset value; the pending result is lost.

## Configuration
- OLOCA_ACC_SATURATE_EN defined: on any carry-out, acc is forced to all ones and stays all ones for the rest of the packet; out_ovf is still set.
- OLOCA_ACC_SATURATE_EN undefined: wrap-around as in Operation.

## Structure
- Shared package oloca_pkg holds:
  - FSM state typedef (ACC, HOLD);
  - a function oloca_add(a, b, imprecise_part) returning {carry, sum}, used by this block and reusable by future OLOCA blocks.
- One natural sub-module, oloca_acc_core: the combinational OLOCA add plus saturation mux. The top level holds the FSM, registers and handshakes.

## Test plan
All scenarios use DATA_WIDTH=16 and I=8. ACC_WIDTH is 32 unless stated.
- Reset: assert rst mid-packet after 2 beats -> outputs 0, in_ready = 1. Next beat 0x0005 with last -> out_sum = 0x5, out_count = 1.
- Beats 0x0010, then 0x0001 with last -> out_sum = 0x3F, out_count = 2, out_ovf = 0.
- Beats 0x00C0, then 0x0080 with last -> out_sum = 0x1FF (carry-in from bit 7 OR), out_count = 2.
- Backpressure: hold out_ready = 0 for 5 cycles after result -> in_ready = 0 and out_* stable throughout. Release -> next packet's first beat is loaded exactly.
- ACC_WIDTH=16; beats 0xFF00, then 0x0100 with last:
  - without the macro -> out_sum = 0x003F, out_ovf = 1;
  - with OLOCA_ACC_SATURATE_EN -> out_sum = 0xFFFF, out_ovf = 1.
- COUNT_WIDTH=2; 5-beat packet of 0x0000 -> out_count = 1 (wrap), out_sum = 0x3F.
